// File: rtl/pcie_status_led_if.sv
// Channel control and LED drive bundle between a status source and the LED block.
// master drives mode/level/event and observes the LED pins; slave is the LED block.
interface pcie_status_led_if #(
   parameter int NUM_CH = 2
);
   logic [2*NUM_CH-1:0] ch_mode;
   logic [NUM_CH-1:0]   ch_level;
   logic [NUM_CH-1:0]   ch_event;
   logic [NUM_CH-1:0]   led_out;
   logic                tick_out;

   modport master (
      output ch_mode, ch_level, ch_event,
      input  led_out, tick_out
   );

   modport slave (
      input  ch_mode, ch_level, ch_event,
      output led_out, tick_out
   );
endinterface

// File: rtl/pcie_status_led.sv
// Status LED driver: per-channel off/solid/blink/activity modes timed by a shared tick.
// led_out and tick_out are registered one cycle after the inputs that decide them; no backpressure.
module pcie_status_led #(
   parameter int NUM_CH        = 2,
   parameter int PRESCALE      = 125000,
   parameter int BLINK_TICKS   = 250,
   parameter int STRETCH_TICKS = 50,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic             user_clk,
   input  logic             user_resetn,
   pcie_status_led_if.slave led_bus
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [PW-1:0] PRE_MAX      = PW'(PRESCALE - 1);
   localparam logic [BW-1:0] BLINK_MAX    = BW'(BLINK_TICKS - 1);
   localparam logic [15:0]   STRETCH_LOAD = 16'(STRETCH_TICKS);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_SOLID = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_ACT   = 2'd3
   } mode_e;

   logic [PW-1:0]     presc;
   logic [BW-1:0]     blink_cnt;
   logic              blink_phase;
   logic              tick;
   logic              tick_q;
   logic [15:0]       stretch     [NUM_CH];
   logic [15:0]       stretch_nxt [NUM_CH];
   logic [NUM_CH-1:0] lit;
   logic [NUM_CH-1:0] led_q;

   assign tick = (presc == PRE_MAX);

   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         presc       <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         presc  <= tick ? '0 : presc + PW'(1);
         tick_q <= tick;
         if (tick) begin
            if (blink_cnt == BLINK_MAX) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + BW'(1);
            end
         end
      end
   end

   // The LED register samples the counter's next value so an event lights the pin one cycle later.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         stretch_nxt[i] = stretch[i];
         if (led_bus.ch_event[i]) begin
            stretch_nxt[i] = STRETCH_LOAD;
         end else if (tick && (stretch[i] != 16'd0)) begin
            stretch_nxt[i] = stretch[i] - 16'd1;
         end

         lit[i] = 1'b0;
         case (mode_e'(led_bus.ch_mode[2*i +: 2]))
            MODE_OFF:   lit[i] = 1'b0;
            MODE_SOLID: lit[i] = led_bus.ch_level[i];
            MODE_BLINK: lit[i] = led_bus.ch_level[i] & blink_phase;
            MODE_ACT:   lit[i] = (stretch_nxt[i] != 16'd0);
            default:    lit[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            stretch[i] <= '0;
         end
         led_q <= {NUM_CH{ACTIVE_LOW}};
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            stretch[i] <= stretch_nxt[i];
         end
         led_q <= lit ^ {NUM_CH{ACTIVE_LOW}};
      end
   end

   assign led_bus.led_out  = led_q;
   assign led_bus.tick_out = tick_q;
endmodule

// File: tb/tb_pcie_status_led.sv
// Scoreboard bench for pcie_status_led with small timing parameters.
// Expected pins for the next cycle are derived from cycle count and event history.
module tb_pcie_status_led;
   localparam int NUM_CH        = 2;
   localparam int PRESCALE      = 4;
   localparam int BLINK_TICKS   = 3;
   localparam int STRETCH_TICKS = 2;

   typedef struct packed {
      logic [NUM_CH-1:0] led;
      logic              tick;
   } obs_t;

   logic user_clk    = 1'b0;
   logic user_resetn = 1'b0;

   pcie_status_led_if #(.NUM_CH(NUM_CH)) led_bus ();

   pcie_status_led #(
      .NUM_CH       (NUM_CH),
      .PRESCALE     (PRESCALE),
      .BLINK_TICKS  (BLINK_TICKS),
      .STRETCH_TICKS(STRETCH_TICKS),
      .ACTIVE_LOW   (1'b1)
   ) dut (
      .user_clk   (user_clk),
      .user_resetn(user_resetn),
      .led_bus    (led_bus)
   );

   always #5 user_clk = ~user_clk;

   int   checks = 0;
   int   passes = 0;
   int   n      = 0;
   int   last_ev [NUM_CH];
   obs_t sb [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, n, got, exp);
   endtask

   // Tick cycles after release are those with cyc % PRESCALE == PRESCALE-1.
   function automatic int ticks_in(input int a, input int b);
      int cnt = 0;
      for (int c = a + 1; c <= b; c++)
         if (c % PRESCALE == PRESCALE - 1) cnt++;
      return cnt;
   endfunction

   function automatic logic phase_at(input int cyc);
      return ((cyc / PRESCALE) / BLINK_TICKS) % 2 == 1;
   endfunction

   // Activity lit in cycle cyc when fewer than STRETCH_TICKS ticks followed the last event.
   function automatic logic act_at(input int ch, input int cyc);
      if (last_ev[ch] < 0) return 1'b0;
      return ticks_in(last_ev[ch], cyc - 1) < STRETCH_TICKS;
   endfunction

   task automatic step(input logic [2*NUM_CH-1:0] mode,
                       input logic [NUM_CH-1:0]   level,
                       input logic [NUM_CH-1:0]   ev);
      obs_t exp_o;
      logic lit;
      led_bus.ch_mode  = mode;
      led_bus.ch_level = level;
      led_bus.ch_event = ev;
      for (int i = 0; i < NUM_CH; i++)
         if (ev[i]) last_ev[i] = n;
      exp_o.tick = (n % PRESCALE == PRESCALE - 1);
      for (int i = 0; i < NUM_CH; i++) begin
         case (mode[2*i +: 2])
            2'd0:    lit = 1'b0;
            2'd1:    lit = level[i];
            2'd2:    lit = level[i] & phase_at(n);
            default: lit = act_at(i, n + 1);
         endcase
         exp_o.led[i] = ~lit;
      end
      sb.push_back(exp_o);
      @(posedge user_clk);
      #1;
      n++;
      exp_o = sb.pop_front();
      chk("led_out", 32'(led_bus.led_out), 32'(exp_o.led));
      chk("tick_out", 32'(led_bus.tick_out), 32'(exp_o.tick));
   endtask

   task automatic do_reset();
      user_resetn = 1'b0;
      #1;
      chk("rst_async_led", 32'(led_bus.led_out), 32'({NUM_CH{1'b1}}));
      chk("rst_async_tick", 32'(led_bus.tick_out), 32'd0);
      led_bus.ch_mode  = '1;
      led_bus.ch_level = '1;
      led_bus.ch_event = '1;
      repeat (3) begin
         @(posedge user_clk);
         #1;
         chk("rst_hold_led", 32'(led_bus.led_out), 32'({NUM_CH{1'b1}}));
         chk("rst_hold_tick", 32'(led_bus.tick_out), 32'd0);
      end
      led_bus.ch_event = '0;
      @(negedge user_clk);
      user_resetn = 1'b1;
      n = 0;
      for (int i = 0; i < NUM_CH; i++) last_ev[i] = -1;
   endtask

   initial begin
      logic [11:0] pat;
      pat = 12'b1011_0011_1010;
      led_bus.ch_mode  = '0;
      led_bus.ch_level = '0;
      led_bus.ch_event = '0;
      for (int i = 0; i < NUM_CH; i++) last_ev[i] = -1;
      @(posedge user_clk);
      #1;
      do_reset();

      // Idle: tick_out every PRESCALE cycles, LEDs dark.
      repeat (14) step('0, '0, '0);

      // Solid on ch0 with a toggling level; ch1 level high but off.
      for (int k = 0; k < 12; k++) step(4'b0001, {1'b1, pat[k]}, '0);

      // Blink on both, then drop and restore level.
      repeat (30) step(4'b1010, 2'b11, '0);
      repeat (4)  step(4'b1010, 2'b00, '0);
      repeat (8)  step(4'b1010, 2'b11, '0);

      // Single activity pulse, then one coincident with a tick.
      step(4'b1100, '0, 2'b10);
      repeat (12) step(4'b1100, '0, '0);
      while (n % PRESCALE != PRESCALE - 1) step(4'b1100, '0, '0);
      step(4'b1100, '0, 2'b10);
      repeat (12) step(4'b1100, '0, '0);

      // Retrigger every 5 cycles.
      for (int k = 0; k < 40; k++) step(4'b1100, '0, (k % 5 == 0) ? 2'b10 : 2'b00);
      repeat (12) step(4'b1100, '0, '0);

      // Reset in the middle of a blink and a stretch.
      step(4'b1110, 2'b01, 2'b10);
      repeat (13) step(4'b1110, 2'b01, '0);
      do_reset();
      repeat (16) step(4'b1110, 2'b01, '0);

      // Pending activity appears when switching into activity mode.
      step(4'b0000, '0, 2'b11);
      repeat (3) step(4'b1111, '0, '0);

      // Random modes, levels and simultaneous events.
      repeat (300) step(4'($urandom), 2'($urandom),
                        ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
